dot16_sequencer: RTL and testbench
==================================

# dot16_sequencer

Sequences a shared pair of 16:1 real-valued operand muxes (row mux and column mux) to compute one dot product of up to 16 element pairs. It drives a common 4-bit element select into both muxes and multiply-accumulates the selected operands into a `real` accumulator. It can add onto its previous result for tiled matrix products, and hands the result downstream over a valid/ready handshake. It sits between the matrix-multiply controller, which issues dot-product jobs, and the operand-mux datapath.

## Interface
Parameters:
- `LEN_W`, default 5: width of the `length` input; values above 16 are clamped to 16.

Ports:
- `clk`, input, 1: sole clock; all state changes on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start_valid`, input, 1: job request.
- `start_ready`, output, 1: job can be accepted; equals (state == IDLE).
- `length`, input, `LEN_W`: number of element pairs, 0..16. Sampled at acceptance.
- `accumulate`, input, 1: at acceptance, 1 seeds the accumulator with the held `result`; 0 seeds it with 0.0.
- `switch`, output, 4: element select, driven to both operand muxes.
- `a_in`, input, real: row-mux output for the current `switch`; combinational.
- `b_in`, input, real: column-mux output for the current `switch`; combinational.
- `result`, output, real: accumulated dot product; holds its value until the next job completes.
- `result_valid`, output, 1: `result` is ready for hand-off; equals (state == DONE).
- `result_ready`, input, 1: downstream accepts `result`.
- `busy`, output, 1: high when state is RUN or DONE.

## Operation
- States are IDLE, RUN and DONE.
- IDLE: `start_ready`=1.
  - On `start_valid`=1, latch `len` = min(`length`, 16) and set `switch`=0, `count`=0.
  - Set `acc` = `accumulate` ? `result` : 0.0.
  - Go to RUN if `len` > 0; otherwise go to DONE, with `result` = `acc`.
- RUN: each cycle, `acc` += `a_in` * `b_in`. The multiply and add are double-precision `real` with no rounding control; the block is simulation-only like the rest of the float datapath.
  - If `count` == `len`-1: `result` takes the final sum, go to DONE, `switch` goes to 0.
  - Otherwise `count`++ and `switch`++.
  - `switch` never wraps past 15 because `len` ≤ 16.
- DONE: `result_valid`=1.
  - On `result_ready`=1, go to IDLE.
  - `start_valid` is ignored in DONE. A new job can be accepted no earlier than the cycle after hand-off.
- `result` changes only when a job reaches DONE, or on reset. Between jobs it holds the last value so `accumulate` can chain jobs.
- Reset (`rst_n`=0, at any time including mid-RUN):
  - state=IDLE, `switch`=0, `count`=0, `acc`=0.0, `result`=0.0.
  - `result_valid`=0, `busy`=0, `start_ready`=1.
  - A job in progress is discarded.

## Timing
- Acceptance edge E0 is the rising edge where IDLE and `start_valid`=1.
- During the cycle after edge Ek (k=0..len-1), `switch`=k. `a_in` and `b_in` must be settled in that same cycle, and the product is sampled at edge Ek+1.
- `result_valid` rises after edge E_len: len cycles after acceptance, or immediately after E0 when len=0.
- The handshake completes at the first edge with `result_valid`=1 and `result_ready`=1. `start_ready` rises after that edge.
- Minimum job-to-job spacing is len+2 cycles: len RUN cycles, 1 DONE cycle with `result_ready` already high, and 1 IDLE acceptance cycle.
- `start_ready`, `result_valid` and `busy` are decoded from the state register only; there is no combinational path from inputs.

## Test plan
- Basic job: length=4, accumulate=0, a[i]=i+1, b[i]=2.0.
  - `switch` steps 0,1,2,3 in consecutive cycles.
  - `result_valid` rises 4 cycles after acceptance with `result`=20.0.
- Full length: length=16, a[i]=1.5, b[i]=i.
  - `result`=180.0, valid 16 cycles after acceptance.
  - `switch` reaches 15, then returns to 0.
- Chaining: run the basic job, then length=2, accumulate=1, a=b=1.0.
  - `result`=22.0.
  - A following job with accumulate=0, length=1, a=3.0, b=3.0 gives `result`=9.0.
- Length edges:
  - length=0 → DONE directly after E0, `result`=0.0 (or the held `result` when accumulate=1).
  - length=20 → clamped; exactly 16 RUN cycles.
- Backpressure: hold `result_ready`=0 for 5 cycles after `result_valid` rises, with `start_valid` pulsed during that window.
  - `result` stays stable and no job is accepted.
  - After `result_ready`=1, the state returns to IDLE and the next `start_valid` is accepted one cycle later.
- Reset mid-job: assert `rst_n`=0 asynchronously while `switch`=7 of a length-16 job.
  - All outputs take their reset values immediately; `result`=0.0.
  - After release, a length-4 job from the basic-job scenario produces 20.0.

Source files
------------

// File: rtl/dot16_sequencer_if.sv
// Job/result handshake and operand-mux bundle for dot16_sequencer.
// The slave side is the sequencer; master is the controller plus mux datapath.
interface dot16_sequencer_if #(
  parameter int LEN_W = 5
);
  logic             start_valid;
  logic             start_ready;
  logic [LEN_W-1:0] length;
  logic             accumulate;
  logic [3:0]       switch;
  real              a_in;
  real              b_in;
  real              result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  modport slave (
    input  start_valid,
    input  length,
    input  accumulate,
    input  a_in,
    input  b_in,
    input  result_ready,
    output start_ready,
    output switch,
    output result,
    output result_valid,
    output busy
  );

  modport master (
    output start_valid,
    output length,
    output accumulate,
    output a_in,
    output b_in,
    output result_ready,
    input  start_ready,
    input  switch,
    input  result,
    input  result_valid,
    input  busy
  );
endinterface

// File: rtl/dot16_sequencer.sv
// Steps a shared 4-bit select through two 16:1 operand muxes and
// multiply-accumulates the pairs; result is handed off valid/ready.
module dot16_sequencer #(
  parameter int LEN_W = 5
) (
  input logic            clk,
  input logic            rst_n,
  dot16_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] sw_q, sw_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] len_q, len_d;
  real        acc_q, acc_d;
  real        res_q, res_d;

  logic [4:0] len_in;
  real        sum;

  generate
    if (LEN_W > 4) begin : g_clamp
      assign len_in = (bus.length > LEN_W'(16))
                    ? 5'd16
                    : 5'(bus.length);
    end else begin : g_narrow
      assign len_in = 5'(bus.length);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sw_q    <= 4'd0;
      cnt_q   <= 4'd0;
      len_q   <= 5'd0;
      acc_q   <= 0.0;
      res_q   <= 0.0;
    end else begin
      state_q <= state_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sw_d    = sw_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    acc_d   = acc_q;
    res_d   = res_q;
    sum     = acc_q + bus.a_in * bus.b_in;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          len_d = len_in;
          sw_d  = 4'd0;
          cnt_d = 4'd0;
          acc_d = bus.accumulate ? res_q : 0.0;
          if (len_in == 5'd0) begin
            res_d   = acc_d;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        acc_d = sum;
        if ({1'b0, cnt_q} == len_q - 5'd1) begin
          res_d   = sum;
          sw_d    = 4'd0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
          sw_d  = sw_q + 4'd1;
        end
      end
      DONE: begin
        // start_valid deliberately ignored until after hand-off
        if (bus.result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.start_ready  = (state_q == IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.busy         = (state_q == RUN)
                          || (state_q == DONE);
  assign bus.switch       = sw_q;
  assign bus.result       = res_q;

endmodule

// File: tb/tb_dot16_sequencer.sv
// Scoreboard bench for dot16_sequencer: directed and random jobs
// against a plain-arithmetic dot-product model.
module tb_dot16_sequencer;
  localparam int LEN_W = 5;

  typedef struct {
    real res;
    int  lat;
    int  t0;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot16_sequencer_if #(.LEN_W(LEN_W)) bus ();

  dot16_sequencer #(.LEN_W(LEN_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  real  a_arr[16];
  real  b_arr[16];
  assign bus.a_in = a_arr[bus.switch];
  assign bus.b_in = b_arr[bus.switch];

  int   vec  = 0;
  int   errs = 0;
  int   cyc  = 0;
  real  held = 0.0;
  exp_t exp_q[$];
  logic rv_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_i(input string nm, input int got, input int want);
    vec++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic chk_r(input string nm, input real got, input real want);
    vec++;
    if (got != want) begin
      errs++;
      $display("FAIL %s: got %f want %f (cyc %0d)", nm, got, want, cyc);
    end
  endtask

  // monitor: pops on each rising result_valid, tracks switch in RUN
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rv_prev = 1'b0;
    end else begin
      if (bus.result_valid && !rv_prev) begin
        if (exp_q.size() == 0) begin
          vec++;
          errs++;
          $display("FAIL spurious_result: got %f want none", bus.result);
        end else begin
          e = exp_q.pop_front();
          chk_r("result", bus.result, e.res);
          chk_i("latency", cyc - e.t0, e.lat);
          chk_i("switch_done", int'(bus.switch), 0);
        end
      end else if (bus.busy && !bus.result_valid
                   && exp_q.size() > 0) begin
        chk_i("switch_run", int'(bus.switch), cyc - exp_q[0].t0);
      end
      rv_prev = bus.result_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!bus.start_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) begin
      vec++;
      errs++;
      $display("FAIL ready_timeout: got 0 want 1");
    end
  endtask

  task automatic issue(input int len, input bit acc);
    exp_t e;
    int   n;
    real  s;
    bus.length      = LEN_W'(len);
    bus.accumulate  = acc;
    bus.start_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    n = (len > 16) ? 16 : len;
    s = acc ? held : 0.0;
    for (int i = 0; i < n; i++) s = s + a_arr[i] * b_arr[i];
    held  = s;
    e.res = s;
    e.lat = n;
    e.t0  = cyc;
    exp_q.push_back(e);
    chk_i("accepted", int'(bus.start_ready), 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = real'(int'($urandom_range(0, 16)) - 8) / 4.0;
      b_arr[i] = real'(int'($urandom_range(0, 16)) - 8) / 4.0;
    end
  endtask

  task automatic basic_ops();
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = real'(i + 1);
      b_arr[i] = 2.0;
    end
  endtask

  initial begin
    int  n;
    real hold_v;
    bus.start_valid  = 1'b0;
    bus.length       = '0;
    bus.accumulate   = 1'b0;
    bus.result_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = 0.0;
      b_arr[i] = 0.0;
    end

    #12;
    chk_i("rst_start_ready", int'(bus.start_ready), 1);
    chk_i("rst_valid", int'(bus.result_valid), 0);
    chk_i("rst_busy", int'(bus.busy), 0);
    chk_i("rst_switch", int'(bus.switch), 0);
    chk_r("rst_result", bus.result, 0.0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed: basic, chaining, full length, length edges
    wait_ready(); basic_ops(); issue(4, 1'b0);
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = 1.0;
      b_arr[i] = 1.0;
    end
    issue(2, 1'b1);
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = 3.0;
      b_arr[i] = 3.0;
    end
    issue(1, 1'b0);
    wait_ready();
    for (int i = 0; i < 16; i++) begin
      a_arr[i] = 1.5;
      b_arr[i] = real'(i);
    end
    issue(16, 1'b0);
    wait_ready(); issue(0, 1'b1);
    wait_ready(); issue(0, 1'b0);
    wait_ready(); rand_ops(); issue(20, 1'b0);

    // backpressure with a stray start pulse in DONE
    wait_ready();
    bus.result_ready = 1'b0;
    rand_ops();
    issue(3, 1'b0);
    hold_v = held;
    n = 0;
    while (!bus.result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_i("bp_valid_rise", int'(bus.result_valid), 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus.start_valid = (k == 1);
      bus.length      = LEN_W'(5);
      chk_r("bp_hold", bus.result, hold_v);
      chk_i("bp_valid", int'(bus.result_valid), 1);
      chk_i("bp_start_ready", int'(bus.start_ready), 0);
    end
    bus.start_valid  = 1'b0;
    bus.result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_i("bp_idle", int'(bus.start_ready), 1);
    rand_ops();
    issue(2, 1'b1);

    // asynchronous reset in the middle of a long job
    wait_ready(); rand_ops(); issue(16, 1'b0);
    n = 0;
    while (bus.switch != 4'd7 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk_i("mid_switch", int'(bus.switch), 7);
    #1 rst_n = 1'b0;
    #1;
    chk_i("mr_start_ready", int'(bus.start_ready), 1);
    chk_i("mr_valid", int'(bus.result_valid), 0);
    chk_i("mr_busy", int'(bus.busy), 0);
    chk_i("mr_switch", int'(bus.switch), 0);
    chk_r("mr_result", bus.result, 0.0);
    exp_q.delete();
    held = 0.0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(); basic_ops(); issue(4, 1'b0);

    // random jobs
    for (int j = 0; j < 25; j++) begin
      wait_ready();
      rand_ops();
      issue(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      vec++;
      errs++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
